// File: rtl/modexp_ladder_seq.sv
// Constant-time modular exponentiation Y = X^E mod N using a Montgomery ladder
// that shares one interleaved shift-add modular multiplier across all steps.
module modexp_ladder_seq #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] x,
  input  logic [W-1:0] e,
  input  logic [W-1:0] n,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] y
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {IDLE, INIT, MUL, SQR, FIN, ERR} state_t;

  state_t         state, state_nx;
  logic [W-1:0]   xr, er, nr, r0, r1;
  logic [W:0]     acc, acc_nx;
  logic [CW-1:0]  kcnt, bidx;
  logic [W-1:0]   ma, mb, prod;
  logic [W:0]     nrx, s0, s1, s2;
  logic           accept, last, ebit;

  // The done cycle is excluded so an accept never coincides with done.
  assign accept = (state == IDLE) && start && !done;
  assign last   = (kcnt == '0);
  assign ebit   = er[bidx];
  assign prod   = acc_nx[W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (n == '0) ? ERR : INIT;
      INIT:    if (last) state_nx = MUL;
      MUL:     if (last) state_nx = SQR;
      SQR:     if (last) state_nx = (bidx == '0) ? FIN : MUL;
      FIN:     state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE) || done;
    ma   = '0;
    mb   = '0;
    case (state)
      INIT: begin
        ma = xr;
        mb = (nr == W'(1)) ? '0 : W'(1);
      end
      MUL: begin
        ma = r0;
        mb = r1;
      end
      SQR: begin
        ma = ebit ? r1 : r0;
        mb = ebit ? r1 : r0;
      end
      default: ;
    endcase
  end

  // One shift-add step: acc < nr on entry keeps every partial sum within W+1 bits.
  always_comb begin
    nrx    = {1'b0, nr};
    s0     = acc << 1;
    s1     = (s0 >= nrx) ? s0 - nrx : s0;
    s2     = ma[kcnt] ? s1 + {1'b0, mb} : s1;
    acc_nx = (s2 >= nrx) ? s2 - nrx : s2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xr   <= '0;
      er   <= '0;
      nr   <= '0;
      r0   <= '0;
      r1   <= '0;
      acc  <= '0;
      kcnt <= '0;
      bidx <= '0;
      done <= 1'b0;
      err  <= 1'b0;
      y    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            xr   <= x;
            er   <= e;
            nr   <= n;
            err  <= 1'b0;
            r0   <= (n == W'(1)) ? '0 : W'(1);
            r1   <= '0;
            acc  <= '0;
            kcnt <= CW'(W - 1);
            bidx <= CW'(W - 1);
          end
        end
        INIT, MUL, SQR: begin
          acc  <= acc_nx;
          kcnt <= kcnt - CW'(1);
          if (last) begin
            acc  <= '0;
            kcnt <= CW'(W - 1);
            case (state)
              INIT: r1 <= prod;
              MUL: begin
                if (ebit) r0 <= prod;
                else      r1 <= prod;
              end
              default: begin
                if (ebit) r1 <= prod;
                else      r0 <= prod;
                if (bidx != '0) bidx <= bidx - CW'(1);
              end
            endcase
          end
        end
        FIN: begin
          y    <= r0;
          done <= 1'b1;
          err  <= 1'b0;
        end
        ERR: begin
          y    <= '0;
          done <= 1'b1;
          err  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_ladder_seq.sv
// Directed bench for modexp_ladder_seq: result, error flag, latency and busy
// timing per job, plus start-handling and mid-job reset sequences.
module tb_modexp_ladder_seq;

  localparam int W      = 8;
  localparam int LAT    = W + 2 * W * W + 1;
  localparam int MAXLAT = 400;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] x = '0, e = '0, n = '0;
  logic         busy, done, err;
  logic [W-1:0] y;

  int n_cmp = 0;
  int n_fail = 0;

  modexp_ladder_seq #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .e(e), .n(n),
    .busy(busy), .done(done), .err(err), .y(y)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] x, e, n, y;
    logic         err;
    int           lat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Counts edges after the sampling edge until done is seen, bounded.
  task automatic wait_done(output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (!busy) busy_ok = 1'b0;
    end while (!done && lat < MAXLAT);
  endtask

  task automatic run_job(input logic [W-1:0] xi, ei, ni,
                         output logic [W-1:0] yo, output logic erro,
                         output int lat, output bit busy_ok);
    @(negedge clk);
    x = xi; e = ei; n = ni; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, busy_ok);
    yo = y;
    erro = err;
  endtask

  initial begin
    logic [W-1:0] gy;
    logic         gerr;
    int           lat;
    bit           bok;

    vecs[0] = '{x:8'd3,   e:8'd5,   n:8'd7,   y:8'd5,   err:1'b0, lat:LAT};
    vecs[1] = '{x:8'd200, e:8'd255, n:8'd251, y:8'd102, err:1'b0, lat:LAT};
    vecs[2] = '{x:8'd2,   e:8'd0,   n:8'd11,  y:8'd1,   err:1'b0, lat:LAT};
    vecs[3] = '{x:8'd9,   e:8'd3,   n:8'd1,   y:8'd0,   err:1'b0, lat:LAT};
    vecs[4] = '{x:8'd0,   e:8'd0,   n:8'd5,   y:8'd1,   err:1'b0, lat:LAT};
    vecs[5] = '{x:8'd250, e:8'd1,   n:8'd7,   y:8'd5,   err:1'b0, lat:LAT};
    vecs[6] = '{x:8'd77,  e:8'd123, n:8'd0,   y:8'd0,   err:1'b1, lat:1};
    vecs[7] = '{x:8'd5,   e:8'd3,   n:8'd13,  y:8'd8,   err:1'b0, lat:LAT};
    vecs[8] = '{x:8'd6,   e:8'd2,   n:8'd7,   y:8'd1,   err:1'b0, lat:LAT};

    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_y", y, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_job(vecs[i].x, vecs[i].e, vecs[i].n, gy, gerr, lat, bok);
      check($sformatf("v%0d_y", i), gy, vecs[i].y);
      check($sformatf("v%0d_err", i), gerr, vecs[i].err);
      check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("v%0d_busy", i), bok, 1);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_idle_busy", i), busy, 0);
      check($sformatf("v%0d_idle_done", i), done, 0);
    end

    // start held high with operands changing mid-job
    @(negedge clk);
    x = 8'd3; e = 8'd5; n = 8'd7; start = 1'b1;
    @(posedge clk);
    #1;
    x = 8'd4; e = 8'd3; n = 8'd11;
    wait_done(lat, bok);
    check("hold_y", y, 5);
    check("hold_lat", lat, LAT);
    check("hold_busy", bok, 1);
    @(posedge clk);
    #1;
    check("hold_gap_busy", busy, 0);
    check("hold_gap_done", done, 0);
    @(posedge clk);
    #1;
    check("hold_reaccept_busy", busy, 1);
    start = 1'b0;
    wait_done(lat, bok);
    check("hold2_y", y, 9);
    check("hold2_lat", lat, LAT);
    @(posedge clk);
    #1;

    // reset in the middle of a job
    @(negedge clk);
    x = 8'd3; e = 8'd5; n = 8'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (59) @(posedge clk);
    #1;
    check("mid_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_err", err, 0);
    check("rst_mid_y", y, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_done", done, 0);
    check("post_rst_busy", busy, 0);
    run_job(8'd200, 8'd255, 8'd251, gy, gerr, lat, bok);
    check("post_rst_y", gy, 102);
    check("post_rst_err", gerr, 0);
    check("post_rst_lat", lat, LAT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
